ll_rd_req_intf: RTL

//  Host-facing read front end for the linked-list engine; sits directly upstream of ll_rd_ctrl.

---
 rtl/ll_pkg.sv | 20 ++
 rtl/ll_req_fifo.sv | 63 ++++++
 rtl/ll_rd_req_intf.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ll_pkg.sv
// Shared widths and types for the linked-list read path.
package ll_pkg;

  localparam int PTR_WD     = 5;
  localparam int WR_DATA_WD = 32;

  typedef struct packed {
    logic              pop;
    logic [PTR_WD-1:0] pos;
  } t_rd_req;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_DATA,
    RESP
  } t_rd_req_st;

endpackage

// File: rtl/ll_req_fifo.sv
// Small request FIFO: count-based full/empty, head word read through a register.
module ll_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage has no reset so it can map onto RAM; head is valid one cycle after write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
    head_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ll_rd_req_intf.sv
// Host read front end for ll_rd_ctrl: queues requests, range-checks, issues one at a time.
// Define LL_RD_TIMEOUT_EN to abort WAIT_DATA with an error after TIMEOUT_CYC cycles.
module ll_rd_req_intf
  import ll_pkg::*;
#(
  parameter int REQ_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_rd_vld,
  output logic                  host_rd_rdy,
  input  logic                  host_rd_pop,
  input  logic [PTR_WD-1:0]     host_rd_pos,
  input  logic [PTR_WD:0]       ll_node_cnt,
  output logic                  rd_req_vld,
  output logic                  rd_req_pop,
  output logic [PTR_WD-1:0]     rd_node_at_pos,
  input  logic                  rd_ctrl_ready,
  input  logic                  rd_data_out_vld,
  input  logic [WR_DATA_WD-1:0] rd_data_out,
  output logic                  resp_vld,
  input  logic                  resp_rdy,
  output logic [WR_DATA_WD-1:0] resp_data,
  output logic                  resp_err
);

  t_rd_req_st            state_q, state_d;
  t_rd_req               req_q, req_d;
  t_rd_req               host_req, fifo_head;
  logic [WR_DATA_WD-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  tmo_hit;

  assign host_req    = '{pop: host_rd_pop, pos: host_rd_pos};
  assign host_rd_rdy = ~fifo_full;
  assign fifo_push   = host_rd_vld & ~fifo_full;

  ll_req_fifo #(
    .WIDTH($bits(t_rd_req)),
    .DEPTH(REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (host_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

`ifdef LL_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == WAIT_DATA) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Zero on the first WAIT_DATA cycle, +1 for every cycle spent there.
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_DATA) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  logic [31:0] timeout_cyc_unused;
  assign timeout_cyc_unused = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    fifo_pop    = 1'b0;
    rd_req_vld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = CHECK;
      end
      CHECK: begin
        if ({1'b0, fifo_head.pos} >= ll_node_cnt) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          fifo_pop    = 1'b1;
          state_d     = RESP;
        end else begin
          req_d   = fifo_head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_ctrl_ready) begin
          rd_req_vld = 1'b1;
          fifo_pop   = 1'b1;
          state_d    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // Data arriving on the abort cycle still wins over the timeout.
        if (rd_data_out_vld) begin
          resp_data_d = rd_data_out;
          resp_err_d  = 1'b0;
          req_d       = '0;
          state_d     = RESP;
        end else if (tmo_hit) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          req_d       = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_rdy) begin
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign rd_req_pop     = req_q.pop;
  assign rd_node_at_pos = req_q.pos;
  assign resp_vld       = (state_q == RESP);
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;

endmodule
